// File: rtl/wb_cmd_formatter.sv
// ============================================================================
// Module  : wb_cmd_formatter
// Purpose : Turns triggered 32-bit host command words into single classic
//           Wishbone read/write cycles; returns read data as a strobe.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wb_cmd_formatter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ep_dataout,
  input  logic              trigger,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [CMD_W-1:0]   cmd;
  logic [CMD_W-1:0]   pend_cmd;
  logic               pend_valid;
  logic [CNT_W-1:0]   cnt;

  logic [CMD_W-1:0]   in_cmd;
  logic               ack_hit;
  logic               to_hit;
  logic               unused_ep;

  // Only we/adr/data fields are kept; the rest of the word is ignored.
  assign in_cmd    = {ep_dataout[31], ep_dataout[24 +: ADDR_W], ep_dataout[DATA_W-1:0]};
  assign unused_ep = ^ep_dataout;

  assign ack_hit = wb_stb_o & wb_ack_i;
  assign to_hit  = (TIMEOUT != 0) && (cnt == CNT_LAST);

  assign wb_we_o  = cmd[CMD_W-1];
  assign wb_adr_o = cmd[DATA_W +: ADDR_W];
  assign wb_dat_o = 32'(cmd[DATA_W-1:0]);
  assign wb_sel_o = wb_stb_o ? 4'hF : 4'h0;
  assign busy     = (state != IDLE) || pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= '0;
      pend_cmd    <= '0;
      pend_valid  <= 1'b0;
      cnt         <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            cmd      <= in_cmd;
            cnt      <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= CYCLE;
          end
        end

        CYCLE: begin
          if (trigger) begin
            if (!pend_valid) begin
              pend_cmd   <= in_cmd;
              pend_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          // Ack takes priority over a timeout landing on the same edge.
          if (ack_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            done     <= 1'b1;
            if (!wb_we_o) begin
              rd_valid <= 1'b1;
              rd_data  <= wb_dat_i;
            end
            state <= DONE;
          end else if (to_hit) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (pend_valid) begin
            cmd        <= pend_cmd;
            pend_valid <= 1'b0;
            cnt        <= '0;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            state      <= CYCLE;
            if (trigger) overflow <= 1'b1;
          end else if (trigger) begin
            // Direct hand-off: no extra bubble beyond this DONE cycle.
            cmd      <= in_cmd;
            cnt      <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= CYCLE;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_formatter.sv
// ============================================================================
// Module  : tb_wb_cmd_formatter
// Purpose : Directed self-checking bench for wb_cmd_formatter (TIMEOUT=8).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ep_dataout;
  logic        trigger;
  logic [6:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        busy;
  logic        overflow;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int n;

  wb_cmd_formatter #(.ADDR_W(7), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ep_dataout(ep_dataout), .trigger(trigger),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .busy(busy), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input logic [31:0] c);
    ep_dataout = c;
    trigger    = 1'b1;
    tick();
    trigger    = 1'b0;
    ep_dataout = '0;
  endtask

  // Keeps ack low for n-1 stb cycles, then acks on the n-th.
  task automatic ack_after(input int cycles, input logic [31:0] d);
    for (int i = 1; i < cycles; i++) tick();
    wb_ack_i = 1'b1;
    wb_dat_i = d;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
  endtask

  initial begin
    rst = 1'b1; ep_dataout = '0; trigger = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    tick(); tick();
    check("rst_stb",   32'(wb_stb_o), 0);
    check("rst_cyc",   32'(wb_cyc_o), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_flags", {30'd0, overflow, timeout_err}, 0);
    rst = 1'b0;

    // Ack with stb low is ignored
    wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
    check("idle_ack_done", 32'(done), 0);

    // Write command, ack on 4th stb cycle
    trig(32'h8512ABCD);
    check("wr_stb", 32'(wb_stb_o), 1);
    check("wr_adr", 32'(wb_adr_o), 32'h05);
    check("wr_we",  32'(wb_we_o), 1);
    check("wr_dat", wb_dat_o, 32'h0000ABCD);
    check("wr_sel", 32'(wb_sel_o), 32'hF);
    tick(); tick(); tick();
    check("wr_stb_4th", 32'(wb_stb_o), 1);
    wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
    check("wr_stb_drop", 32'(wb_stb_o), 0);
    check("wr_sel_drop", 32'(wb_sel_o), 0);
    check("wr_done",     32'(done), 1);
    check("wr_rdv",      32'(rd_valid), 0);
    tick();
    check("wr_done_end", 32'(done), 0);
    check("wr_idle",     32'(busy), 0);

    // Read command
    trig(32'h01000000);
    check("rd_adr", 32'(wb_adr_o), 32'h01);
    check("rd_we",  32'(wb_we_o), 0);
    ack_after(2, 32'hDEADBEEF);
    check("rd_valid", 32'(rd_valid), 1);
    check("rd_data",  rd_data, 32'hDEADBEEF);
    check("rd_done",  32'(done), 1);
    tick();
    check("rd_valid_end", 32'(rd_valid), 0);
    check("rd_hold",      rd_data, 32'hDEADBEEF);

    // Three back-to-back triggers: 1 runs, 2 pends, 3 dropped
    trig(32'h03000011);
    trig(32'h04000022);
    trig(32'h05000033);
    check("ovf_set",  32'(overflow), 1);
    check("ovf_adr1", 32'(wb_adr_o), 32'h03);
    check("ovf_busy", 32'(busy), 1);
    wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
    check("q_gap_stb", 32'(wb_stb_o), 0);
    check("q_done1",   32'(done), 1);
    tick();
    check("q_stb2", 32'(wb_stb_o), 1);
    check("q_adr2", 32'(wb_adr_o), 32'h04);
    check("q_dat2", wb_dat_o, 32'h00000022);
    ack_after(1, 32'h0);
    check("q_done2", 32'(done), 1);
    tick();
    check("q_no3_stb",  32'(wb_stb_o), 0);
    check("q_no3_busy", 32'(busy), 0);

    // Timeout with no ack
    trig(32'h06000000);
    n = 0;
    while (wb_stb_o && n < 20) begin
      n++;
      tick();
    end
    check("to_len",  32'(n), 8);
    check("to_done", 32'(done), 1);
    check("to_err",  32'(timeout_err), 1);
    check("to_rdv",  32'(rd_valid), 0);
    tick();
    trig(32'h07000000);
    ack_after(3, 32'h12345678);
    check("to_next_rdv",  32'(rd_valid), 1);
    check("to_next_data", rd_data, 32'h12345678);
    check("to_err_stick", 32'(timeout_err), 1);
    tick();

    // Trigger coincident with ack goes to pending slot
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_flags", {30'd0, overflow, timeout_err}, 0);
    trig(32'h08000000);
    tick();
    wb_ack_i = 1'b1; trigger = 1'b1; ep_dataout = 32'h09000000;
    tick();
    wb_ack_i = 1'b0; trigger = 1'b0; ep_dataout = '0;
    check("co_done", 32'(done), 1);
    check("co_stb0", 32'(wb_stb_o), 0);
    check("co_busy", 32'(busy), 1);
    tick();
    check("co_stb1", 32'(wb_stb_o), 1);
    check("co_adr",  32'(wb_adr_o), 32'h09);
    check("co_ovf",  32'(overflow), 0);
    ack_after(1, 32'h0);
    tick();

    // Reset mid-cycle with pending command and overflow set
    trig(32'h0A000000);
    trig(32'h0B000000);
    trig(32'h0C000000);
    check("mr_pre_ovf", 32'(overflow), 1);
    check("mr_pre_stb", 32'(wb_stb_o), 1);
    rst = 1'b1; tick();
    check("mr_stb",  32'(wb_stb_o), 0);
    check("mr_cyc",  32'(wb_cyc_o), 0);
    check("mr_done", 32'(done), 0);
    check("mr_flags", {30'd0, overflow, timeout_err}, 0);
    rst = 1'b0;
    tick(); tick();
    check("mr_no_pend_stb",  32'(wb_stb_o), 0);
    check("mr_no_pend_busy", 32'(busy), 0);
    check("mr_no_done",      32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
